// File: rtl/axi_rd_master_if.sv
// AXI4 read-channel bundle (AR + R) between the read initiator and a memory-side slave.
interface axi_rd_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_master.sv
// AXI4 read initiator: turns client (addr, len) requests into INCR AR bursts with
// rotating IDs, tracks bursts in flight in order, passes R beats straight through to
// the client and flags ID/length/response errors per beat.
// Build option: define AXI_RD_LAT_STATS_EN to add lat_last/lat_min/lat_max outputs
// (AR handshake to first R beat, saturating 16-bit cycle counts).
module axi_rd_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [7:0]                         req_len,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_data,
    output logic                               rsp_last,
    output logic                               rsp_err,
    axi_rd_master_if.master                    m_axi,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_sticky
`ifdef AXI_RD_LAT_STATS_EN
    ,
    output logic [15:0]                        lat_last,
    output logic [15:0]                        lat_min,
    output logic [15:0]                        lat_max
`endif
);
    localparam int PTR_W     = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W     = PTR_W + 1;
    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    localparam logic [CNT_W-1:0]      MAX_CNT    = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ADDR} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  ar_valid;
    logic                  ar_hs;
    logic                  req_hs;
    logic                  r_hs;
    logic                  pop;
    logic                  trk_empty;
    logic                  beat_err;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic [3:0]            ar_cache;
    logic [PTR_W-1:0]      id_cnt;

    logic [ID_WIDTH-1:0]   trk_id  [MAX_OUTSTANDING];
    logic [7:0]            trk_len [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [7:0]            beat_cnt;

    assign req_hs    = req_valid && req_ready;
    assign ar_hs     = ar_valid && m_axi.arready;
    assign r_hs      = m_axi.rvalid && rsp_ready;
    assign trk_empty = (outstanding == '0);
    assign pop       = r_hs && m_axi.rlast && !trk_empty;

    // AR FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // AR FSM next state: one request accepted at a time, held until arready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs) state_nxt = ADDR;
            ADDR:    if (m_axi.arready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // AR FSM outputs
    always_comb begin
        req_ready = (state == IDLE) && (outstanding < MAX_CNT);
        ar_valid  = (state == ADDR);
    end

    // AR fields captured on request accept, stable while arvalid is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_id    <= '0;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            ar_cache <= '0;
        end else if (req_hs) begin
            ar_id    <= ID_WIDTH'(id_cnt);
            ar_addr  <= req_addr & ALIGN_MASK;
            ar_len   <= req_len;
            ar_size  <= 3'(SIZE_LOG2);
            ar_burst <= 2'b01;
            ar_cache <= 4'b0011;
        end
    end

    assign m_axi.arid    = ar_id;
    assign m_axi.araddr  = ar_addr;
    assign m_axi.arlen   = ar_len;
    assign m_axi.arsize  = ar_size;
    assign m_axi.arburst = ar_burst;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = ar_cache;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = ar_valid;

    // ID rotation, tracker pointers and in-flight count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_cnt      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (ar_hs) begin
                id_cnt <= id_cnt + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            outstanding <= outstanding + CNT_W'(ar_hs) - CNT_W'(pop);
        end
    end

    // Tracker payload; validity is carried entirely by the pointers
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            trk_id[wr_ptr]  <= ar_id;
            trk_len[wr_ptr] <= ar_len;
        end
    end

    // Beat counter within the current burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      beat_cnt <= '0;
        else if (r_hs) beat_cnt <= m_axi.rlast ? 8'd0 : beat_cnt + 8'd1;
    end

    // Per-beat protocol check against the oldest outstanding burst
    always_comb begin
        beat_err = 1'b0;
        if (trk_empty) begin
            beat_err = 1'b1;
        end else if ((m_axi.rid != trk_id[rd_ptr]) ||
                     (m_axi.rlast != (beat_cnt == trk_len[rd_ptr]))) begin
            beat_err = 1'b1;
        end
        if (m_axi.rresp != 2'b00) beat_err = 1'b1;
    end

    assign rsp_valid    = m_axi.rvalid;
    assign rsp_data     = m_axi.rdata;
    assign rsp_last     = m_axi.rlast;
    assign rsp_err      = m_axi.rvalid && beat_err;
    assign m_axi.rready = rsp_ready;

    // Sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 err_sticky <= 1'b0;
        else if (r_hs && rsp_err) err_sticky <= 1'b1;
    end

`ifdef AXI_RD_LAT_STATS_EN
    logic [15:0] trk_age [MAX_OUTSTANDING];
    logic        first_beat;
    logic [15:0] lat_cur;

    assign first_beat = r_hs && !trk_empty && (beat_cnt == 8'd0);
    assign lat_cur    = trk_age[rd_ptr];

    // Per-entry age: starts at 1 the cycle after the AR handshake, saturates
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ar_hs && (wr_ptr == PTR_W'(i)))  trk_age[i] <= 16'd1;
            else if (trk_age[i] != 16'hFFFF)    trk_age[i] <= trk_age[i] + 16'd1;
        end
    end

    // Latency statistics updated on the first beat of each tracked burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
        end else if (first_beat) begin
            lat_last <= lat_cur;
            if (lat_cur < lat_min) lat_min <= lat_cur;
            if (lat_cur > lat_max) lat_max <= lat_cur;
        end
    end
`endif
endmodule

// File: tb/tb_axi_rd_master.sv
// Bench for axi_rd_master: randomized client/slave traffic checked every cycle
// against a queue-based model, plus directed scenarios with literal expectations.
module tb_axi_rd_master;
    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic [2:0]  outstanding;
    logic        err_sticky;
`ifdef AXI_RD_LAT_STATS_EN
    logic [15:0] lat_last, lat_min, lat_max;
`endif

    axi_rd_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) axi ();

    axi_rd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .m_axi(axi), .outstanding(outstanding), .err_sticky(err_sticky)
`ifdef AXI_RD_LAT_STATS_EN
        , .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    typedef struct { logic [7:0] id; logic [7:0] len; int t; } trk_t;
    trk_t        mq[$];
    int          mbeat;
    bit          pend;
    int          idc;
    bit          msticky;
    logic [7:0]  e_arid, e_arlen;
    logic [15:0] e_araddr;
    logic [2:0]  e_arsize;
    logic [1:0]  e_arburst;
    logic [3:0]  e_arcache;
    int          m_last, m_min, m_max;

    // logs for directed literal checks
    logic [15:0] arlog_addr[$];
    logic [7:0]  arlog_id[$];
    logic [7:0]  arlog_len[$];
    bit          blog_last[$];
    bit          blog_err[$];
    logic [31:0] blog_data[$];

    // ---------------- stimulus state ----------------
    logic [15:0] rq_addr[$];
    logic [7:0]  rq_len[$];
    typedef struct { logic [7:0] id; logic [7:0] len; int beat; int t; bit early; bit badid; } sb_t;
    sb_t         sq[$];
    bit          r_taken = 0;
    bit          ar_hold = 0, r_hold = 0;
    int          ar_pct = 100, rv_pct = 100, rr_mode = 0, err_pct = 0, gap = 1;
    bit          rand_early = 0, next_early = 0, next_badid = 0;
    int          dseq = 32'h1000;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        pend = 0; mq.delete(); mbeat = 0; idc = 0; msticky = 0;
        e_arid = '0; e_arlen = '0; e_araddr = '0; e_arsize = '0; e_arburst = '0; e_arcache = '0;
        m_last = 0; m_min = 65535; m_max = 0;
    endfunction

    function automatic void clear_logs();
        arlog_addr.delete(); arlog_id.delete(); arlog_len.delete();
        blog_last.delete(); blog_err.delete(); blog_data.delete();
    endfunction

    task automatic drive();
        int last_idx;
        req_valid = (rq_addr.size() > 0);
        req_addr  = req_valid ? rq_addr[0] : 16'h0;
        req_len   = req_valid ? rq_len[0] : 8'h0;
        axi.arready = !ar_hold && ($urandom_range(99) < ar_pct);
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = !rsp_ready;
            default: rsp_ready = 1'($urandom_range(1));
        endcase
        if (axi.rvalid && !r_taken) begin
            // beat still pending: hold everything
        end else if (sq.size() > 0 && !r_hold && (sq[0].beat > 0 || cyc + 1 - sq[0].t >= gap) &&
                     $urandom_range(99) < rv_pct) begin
            last_idx   = (sq[0].early && sq[0].len > 0) ? int'(sq[0].len) - 1 : int'(sq[0].len);
            axi.rlast  = (sq[0].beat == last_idx);
            axi.rid    = sq[0].badid ? (sq[0].id ^ 8'h01) : sq[0].id;
            axi.rresp  = 2'b00;
            if (err_pct > 0 && $urandom_range(99) < err_pct) begin
                if ($urandom_range(1) == 0) axi.rresp = 2'b10;
                else                        axi.rid   = sq[0].id ^ 8'h02;
            end
            axi.rdata  = 32'(dseq);
            dseq++;
            axi.rvalid = 1'b1;
        end else begin
            axi.rvalid = 1'b0;
        end
    endtask

    // One clock: compare at the falling edge, advance model, drive after the rising edge.
    task automatic step();
        logic exp_rr, exp_err, rhs, reqhs;
        int   lat;
        @(negedge clk);
        cyc++;
        if (!rst) model_reset();
        exp_rr = !pend && (mq.size() < MAX_OUT);
        chk("req_ready", req_ready, exp_rr);
        chk("outstanding", outstanding, mq.size());
        chk("arvalid", axi.arvalid, pend);
        chk("arid", axi.arid, e_arid);
        chk("araddr", axi.araddr, e_araddr);
        chk("arlen", axi.arlen, e_arlen);
        chk("arsize", axi.arsize, e_arsize);
        chk("arburst", axi.arburst, e_arburst);
        chk("arcache", axi.arcache, e_arcache);
        chk("arlock", axi.arlock, 0);
        chk("arprot", axi.arprot, 0);
        chk("rsp_valid", rsp_valid, axi.rvalid);
        chk("rsp_data", rsp_data, axi.rdata);
        chk("rsp_last", rsp_last, axi.rlast);
        chk("m_axi_rready", axi.rready, rsp_ready);
        chk("err_sticky", err_sticky, msticky);
        if (mq.size() == 0) exp_err = 1'b1;
        else exp_err = (axi.rid != mq[0].id) || (axi.rlast != (mbeat == int'(mq[0].len))) ||
                       (axi.rresp != 2'b00);
        if (axi.rvalid) chk("rsp_err", rsp_err, exp_err);
`ifdef AXI_RD_LAT_STATS_EN
        chk("lat_last", lat_last, m_last);
        chk("lat_min", lat_min, m_min);
        chk("lat_max", lat_max, m_max);
`endif
        rhs   = axi.rvalid && rsp_ready;
        reqhs = req_valid && exp_rr;
        if (rst) begin
            if (rhs) begin
                blog_last.push_back(axi.rlast);
                blog_err.push_back(exp_err);
                blog_data.push_back(axi.rdata);
                if (exp_err) msticky = 1;
                if (mq.size() > 0) begin
                    if (mbeat == 0) begin
                        lat = cyc - mq[0].t;
                        if (lat > 65535) lat = 65535;
                        m_last = lat;
                        if (lat < m_min) m_min = lat;
                        if (lat > m_max) m_max = lat;
                    end
                    if (axi.rlast) void'(mq.pop_front());
                end
                mbeat = axi.rlast ? 0 : (mbeat + 1) % 256;
            end
            if (pend && axi.arready) begin
                mq.push_back('{id: e_arid, len: e_arlen, t: cyc});
                arlog_addr.push_back(e_araddr);
                arlog_id.push_back(e_arid);
                arlog_len.push_back(e_arlen);
                idc  = (idc + 1) % MAX_OUT;
                pend = 0;
            end
            if (reqhs) begin
                pend      = 1;
                e_araddr  = req_addr & 16'hFFFC;
                e_arlen   = req_len;
                e_arid    = 8'(idc);
                e_arsize  = 3'd2;
                e_arburst = 2'b01;
                e_arcache = 4'b0011;
                void'(rq_addr.pop_front());
                void'(rq_len.pop_front());
            end
        end
        // slave side bookkeeping follows the bus regardless of reset
        if (rhs && sq.size() > 0) begin
            sq[0].beat++;
            if (axi.rlast) void'(sq.pop_front());
        end
        if (axi.arvalid && axi.arready) begin
            sq.push_back('{id: axi.arid, len: axi.arlen, beat: 0, t: cyc,
                           early: next_early || (rand_early && $urandom_range(99) < 10),
                           badid: next_badid});
            next_early = 0;
            next_badid = 0;
        end
        r_taken = rhs;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            step();
            done = (rq_addr.size() == 0) && !pend && (mq.size() == 0) && (sq.size() == 0) && !axi.rvalid;
        end
        chk("idle_reached", done, 1);
    endtask

    task automatic push_req(input logic [15:0] a, input logic [7:0] l);
        rq_addr.push_back(a);
        rq_len.push_back(l);
    endtask

    initial begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0;
        axi.rresp = '0; axi.rlast = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_outstanding", outstanding, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_err_sticky", err_sticky, 0);
        rst = 1'b1;
        clear_logs();

        // single burst, aligned
        push_req(16'h0040, 8'd3);
        wait_idle();
        chk("t1_araddr", arlog_addr[0], 16'h0040);
        chk("t1_arlen", arlog_len[0], 3);
        chk("t1_arid", arlog_id[0], 0);
        chk("t1_beats", blog_last.size(), 4);
        chk("t1_last3", blog_last[3], 1);
        chk("t1_last2", blog_last[2], 0);
        chk("t1_err0", blog_err[0], 0);
        chk("t1_err3", blog_err[3], 0);

        // unaligned address
        push_req(16'h0043, 8'd0);
        wait_idle();
        chk("t2_araddr", arlog_addr[1], 16'h0040);
        chk("t2_arid", arlog_id[1], 1);

        // back-to-back with arready held low, then release
        do_reset();
        ar_hold = 1; r_hold = 1;
        for (int i = 0; i < 5; i++) push_req(16'(16'h0100 * i), 8'd1);
        repeat (4) step();
        chk("t3_req_ready_addr", req_ready, 0);
        chk("t3_arvalid_hold", axi.arvalid, 1);
        chk("t3_outst0", outstanding, 0);
        ar_hold = 0;
        repeat (12) step();
        chk("t3_outst4", outstanding, 4);
        chk("t3_req_ready_full", req_ready, 0);
        chk("t3_pending_reqs", rq_addr.size(), 1);
        chk("t3_ar_count", arlog_id.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_arid", arlog_id[i], i);
        r_hold = 0;
        wait_idle();
        chk("t3_ar5_count", arlog_id.size(), 5);
        chk("t3_arid5", arlog_id[4], 0);

        // early rlast
        do_reset();
        next_early = 1;
        push_req(16'h0200, 8'd3);
        wait_idle();
        chk("t4_beats", blog_last.size(), 3);
        chk("t4_err0", blog_err[0], 0);
        chk("t4_last2", blog_last[2], 1);
        chk("t4_err2", blog_err[2], 1);
        chk("t4_sticky", err_sticky, 1);

        // rid mismatch
        do_reset();
        next_badid = 1;
        push_req(16'h0300, 8'd3);
        wait_idle();
        chk("t4b_beats", blog_last.size(), 4);
        chk("t4b_err0", blog_err[0], 1);
        chk("t4b_sticky", err_sticky, 1);

        // rsp_ready toggling, len 7
        do_reset();
        begin
            int d0;
            d0 = dseq;
            rr_mode = 1;
            push_req(16'h0400, 8'd7);
            wait_idle();
            rr_mode = 0;
            chk("t5_beats", blog_data.size(), 8);
            for (int i = 0; i < 8; i++) chk("t5_data", blog_data[i], 32'(d0 + i));
            chk("t5_last7", blog_last[7], 1);
            chk("t5_last6", blog_last[6], 0);
        end

`ifdef AXI_RD_LAT_STATS_EN
        do_reset();
        chk("t6_rst_min", lat_min, 16'hFFFF);
        gap = 9;
        push_req(16'h0500, 8'd0);
        wait_idle();
        gap = 3;
        push_req(16'h0504, 8'd0);
        wait_idle();
        gap = 1;
        chk("t6_lat_last", lat_last, 3);
        chk("t6_lat_min", lat_min, 3);
        chk("t6_lat_max", lat_max, 9);
`endif

        // randomized traffic with error injection and a reset mid-flight
        do_reset();
        ar_pct = 70; rv_pct = 70; rr_mode = 2; err_pct = 4; rand_early = 1;
        for (int i = 0; i < 3000; i++) begin
            if (rq_addr.size() < 3 && $urandom_range(3) == 0)
                push_req(16'($urandom), 8'($urandom_range(5)));
            if (i == 1500) begin
                rst = 1'b0;
                step();
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end
        ar_pct = 100; rv_pct = 100; rr_mode = 0; err_pct = 0; rand_early = 0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
